sopc_cpu_jtag_ocimem: RTL and testbench
=======================================

Name: sopc_cpu_jtag_ocimem

Overview:
- Sysclk-domain consumer of the JTAG debug module's decoded actions (jdo, take_action_ocimem_*). Producer of MonDReg, monitor_ready and monitor_error, which feed back to the debug module.
- Contains the on-chip debug monitor RAM, the JTAG address/data monitor registers and a small monitor control register.
- CPU-side Avalon-MM slave gives the Nios II access to monitor code and data.
- JTAG accesses always win over the CPU port.

Parameters:
- RAM_ADDR_W, 8, word-address width of the monitor RAM (depth 2**RAM_ADDR_W x 32 bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- jdo  in  38  JTAG data field from the debug module sysclk stage
- take_action_ocimem_a  in  1  single-cycle pulse: load address / control command
- take_no_action_ocimem_a  in  1  single-cycle pulse: read at next address
- take_action_ocimem_b  in  1  single-cycle pulse: write data at current address
- avs_address  in  RAM_ADDR_W+1  word address; MSB=1 selects control register
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte lanes
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  CPU stall
- MonDReg  out  32  JTAG-visible data register
- monitor_ready  out  1  monitor reports ready
- monitor_error  out  1  monitor reports error
- monitor_go  out  1  host request for the monitor to run

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, monitor_go=0, avs_readdata=0.
  - FSM in IDLE; RAM contents undefined.
  - avs_waitrequest=1 while reset_n=0 and in the first cycle after deassertion.
- MonAReg: internal RAM_ADDR_W-bit word address, wraps modulo depth.
- RAM: synchronous, 1-cycle read latency, per-byte write enables.
- JTAG commands are sampled in IDLE only. The debug module guarantees at most one pulse per 4 clk.
  - take_action_ocimem_a:
    - MonAReg <= jdo[26+RAM_ADDR_W-1:26].
    - If jdo[35]=1: monitor_go <= 1, monitor_ready <= 0, monitor_error <= 0.
    - If jdo[34]=1: go to JRD.
    - Otherwise stay in IDLE.
  - take_no_action_ocimem_a: MonAReg <= MonAReg+1, then JRD.
  - take_action_ocimem_b: go to JWR with data jdo[34:3].
  - Priority when pulses coincide: ocimem_b > action_a > no_action_a.
- FSM states: IDLE, JRD, JRD_CAP, JWR, CRD.
  - JRD: drive RAM address = MonAReg → JRD_CAP.
  - JRD_CAP: MonDReg <= RAM q → IDLE. JTAG read latency is 2 clk from the pulse to MonDReg update.
  - JWR: write all 4 bytes at MonAReg; MonAReg <= MonAReg+1; MonDReg <= written data → IDLE.
  - CRD (CPU RAM read): readdata <= RAM q, waitrequest=0 this cycle → IDLE.
- CPU port, accepted only in IDLE with no JTAG pulse present; otherwise avs_waitrequest=1 and the request is held.
  - RAM write: completes in the accept cycle with waitrequest=0, byteenable honoured.
  - RAM read: accept cycle has waitrequest=1 → CRD.
  - Control register (MSB=1) reads/writes complete in 1 cycle with waitrequest=0.
    - Read value: {29'b0, monitor_go, monitor_error, monitor_ready}.
    - Write with byteenable[0]: bit0=1 sets monitor_ready, bit1=1 sets monitor_error, bit2=1 clears monitor_go. Zeros have no effect.
  - Simultaneous JTAG pulse and CPU request in IDLE: JTAG wins; CPU waits.
- Reset mid-operation returns to IDLE immediately. Any in-flight CPU access is dropped, with no partial write beyond what already reached RAM.

Optional Feature:
- Macro: SOPC_OCIMEM_PARITY_EN.
- Defined:
  - RAM stores 4 even-parity bits per word, one per byte, updated per written byte.
  - Any read (JRD_CAP or CRD) with a parity mismatch sets monitor_error sticky, cleared only by a take_action_ocimem_a command with jdo[35]=1 or by reset.
  - Data is still returned unmodified.
- Not defined: no parity storage; monitor_error is set only by CPU write.

Decomposition:
- Shared package sopc_cpu_ocimem_pkg:
  - FSM state enum.
  - jdo field constants: JDO_ADDR_LSB=26, JDO_RD_BIT=34, JDO_GO_BIT=35, JDO_WDATA_LSB=3.
  - Control bit indices.
- One sub-module: sopc_cpu_ocimem_ram, a byte-enabled synchronous single-port RAM with optional parity lanes.

Test Plan:
- JTAG write then read:
  - Stimulus: action_a with addr=0x10, jdo[34]=0; then ocimem_b with data 0xDEADBEEF; then action_a with addr=0x10, jdo[34]=1.
  - Required: MonDReg=0xDEADBEEF exactly 2 clk after the last pulse; MonAReg=0x10.
- Auto-increment wrap:
  - Stimulus: set MonAReg=0xFF; pulse no_action_a.
  - Required: reads RAM[0x00] into MonDReg.
- CPU byte write:
  - Stimulus: write 0x11223344 to word 5 with byteenable=0b0101; then CPU read of word 5 (prior RAM content 0).
  - Required: readdata=0x00220044; waitrequest=1 for exactly 1 cycle.
- Arbitration:
  - Stimulus: CPU read asserted in the same cycle as take_action_ocimem_b.
  - Required: JTAG write commits first; CPU waitrequest stays high until the FSM returns to IDLE, then the read completes with the new data.
- Control handshake:
  - Stimulus: action_a with jdo[35]=1; CPU writes 0x1 to the control register; CPU reads the control register.
  - Required: monitor_go=1 after the pulse; monitor_ready=1 after the write; read returns 0x5.
- Async reset:
  - Stimulus: reset_n low in JRD_CAP.
  - Required: MonDReg=0, FSM IDLE, waitrequest=1; no MonDReg update after release.

Source files
------------

// File: rtl/sopc_cpu_ocimem_pkg.sv
// Shared types and constants for the JTAG on-chip monitor memory block.
`default_nettype none

package sopc_cpu_ocimem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_JRD     = 3'd1,
    ST_JRD_CAP = 3'd2,
    ST_JWR     = 3'd3,
    ST_CRD     = 3'd4
  } ocimem_state_e;

  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_GO_BIT    = 35;
  localparam int JDO_WDATA_LSB = 3;

  localparam int CTL_READY_BIT = 0;
  localparam int CTL_ERROR_BIT = 1;
  localparam int CTL_GO_BIT    = 2;

  // One even-parity bit per byte lane.
  function automatic logic [3:0] byte_parity(input logic [31:0] d);
    byte_parity = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sopc_cpu_ocimem_ram.sv
// Byte-enabled synchronous single-port monitor RAM, 1-cycle read latency.
// SOPC_OCIMEM_PARITY_EN adds per-byte parity lanes and a read-side mismatch flag.
`default_nettype none

module sopc_cpu_ocimem_ram
  import sopc_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              par_err
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

`ifdef SOPC_OCIMEM_PARITY_EN
  logic [3:0] par_mem [2**ADDR_W];
  logic [3:0] par_q;
  logic [3:0] w_par_in;

  assign w_par_in = byte_parity(wdata);

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) par_mem[addr][b] <= w_par_in[b];
    end
    par_q <= par_mem[addr];
  end

  assign par_err = |(par_q ^ byte_parity(rdata_q));
`else
  assign par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/sopc_cpu_jtag_ocimem.sv
// Sysclk-side JTAG monitor memory: monitor RAM, MonAReg/MonDReg, control register, CPU slave.
// Optional parity checking is enabled by defining SOPC_OCIMEM_PARITY_EN.
`default_nettype none

module sopc_cpu_jtag_ocimem
  import sopc_cpu_ocimem_pkg::*;
#(
  parameter int RAM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [RAM_ADDR_W:0]   avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  logic [3:0]            avs_byteenable,
  output logic [31:0]           avs_readdata,
  output logic                  avs_waitrequest,
  output logic [31:0]           MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  output logic                  monitor_go
);

  localparam logic [RAM_ADDR_W-1:0] ADDR_ONE = 1;

  ocimem_state_e           state_q, state_d;
  logic [RAM_ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]             mon_d_q, mon_d_d;
  logic [31:0]             jwdata_q, jwdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    go_q, go_d;
  logic                    init_q;

  logic [RAM_ADDR_W-1:0]   ram_addr;
  logic [3:0]              ram_we;
  logic [31:0]             ram_wdata;
  logic [31:0]             ram_q;
  logic                    ram_perr;
  logic                    unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  sopc_cpu_ocimem_ram #(.ADDR_W(RAM_ADDR_W)) u_ram (
    .clk     (clk),
    .addr    (ram_addr),
    .we      (ram_we),
    .wdata   (ram_wdata),
    .rdata   (ram_q),
    .par_err (ram_perr)
  );

  always_comb begin
    state_d         = state_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    jwdata_d        = jwdata_q;
    ready_d         = ready_q;
    error_d         = error_q;
    go_d            = go_q;
    ram_addr        = avs_address[RAM_ADDR_W-1:0];
    ram_we          = 4'b0000;
    ram_wdata       = avs_writedata;
    avs_waitrequest = 1'b1;
    avs_readdata    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          jwdata_d = jdo[JDO_WDATA_LSB +: 32];
          state_d  = ST_JWR;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[JDO_ADDR_LSB +: RAM_ADDR_W];
          if (jdo[JDO_GO_BIT]) begin
            go_d    = 1'b1;
            ready_d = 1'b0;
            error_d = 1'b0;
          end
          if (jdo[JDO_RD_BIT]) state_d = ST_JRD;
        end else if (take_no_action_ocimem_a) begin
          mon_a_d = mon_a_q + ADDR_ONE;
          state_d = ST_JRD;
        end else if (init_q && (avs_read || avs_write)) begin
          // CPU port only gets the RAM when no JTAG command is pending.
          if (avs_address[RAM_ADDR_W]) begin
            avs_waitrequest = 1'b0;
            if (avs_write) begin
              if (avs_byteenable[0]) begin
                if (avs_writedata[CTL_READY_BIT]) ready_d = 1'b1;
                if (avs_writedata[CTL_ERROR_BIT]) error_d = 1'b1;
                if (avs_writedata[CTL_GO_BIT])    go_d    = 1'b0;
              end
            end else begin
              avs_readdata = {29'b0, go_q, error_q, ready_q};
            end
          end else if (avs_write) begin
            ram_we          = avs_byteenable;
            avs_waitrequest = 1'b0;
          end else begin
            state_d = ST_CRD;
          end
        end
      end
      ST_JRD: begin
        ram_addr = mon_a_q;
        state_d  = ST_JRD_CAP;
      end
      ST_JRD_CAP: begin
        mon_d_d = ram_q;
        if (ram_perr) error_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_JWR: begin
        ram_addr  = mon_a_q;
        ram_we    = 4'b1111;
        ram_wdata = jwdata_q;
        mon_a_d   = mon_a_q + ADDR_ONE;
        mon_d_d   = jwdata_q;
        state_d   = ST_IDLE;
      end
      ST_CRD: begin
        avs_readdata    = ram_q;
        avs_waitrequest = 1'b0;
        if (ram_perr) error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rdata_d = avs_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mon_a_q  <= '0;
      mon_d_q  <= '0;
      jwdata_q <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      go_q     <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mon_a_q  <= mon_a_d;
      mon_d_q  <= mon_d_d;
      jwdata_q <= jwdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      go_q     <= go_d;
      init_q   <= 1'b1;
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign monitor_go    = go_q;

endmodule

`default_nettype wire

// File: tb/tb_sopc_cpu_jtag_ocimem.sv
// Directed plus randomized bench for sopc_cpu_jtag_ocimem against a word-array reference model.
`default_nettype none

module tb_sopc_cpu_jtag_ocimem;
  import sopc_cpu_ocimem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [8:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;

  sopc_cpu_jtag_ocimem #(.RAM_ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .monitor_go(monitor_go)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: RAM image, address pointer, data register, control bits.
  logic [31:0] m_mem [256];
  logic [7:0]  m_a;
  logic [31:0] m_d;
  logic        m_go, m_err, m_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag);
    chk({tag, "_go"},  {31'b0, monitor_go},    {31'b0, m_go});
    chk({tag, "_err"}, {31'b0, monitor_error}, {31'b0, m_err});
    chk({tag, "_rdy"}, {31'b0, monitor_ready}, {31'b0, m_rdy});
  endtask

  // Pulse issued; MonDReg must change exactly on the second edge after it.
  task automatic jtag_read_tail(input string tag);
    step();
    chk({tag, "_early"}, MonDReg, m_d);
    step();
    m_d = m_mem[m_a];
    chk({tag, "_data"}, MonDReg, m_d);
    chk({tag, "_addr"}, {24'b0, dut.mon_a_q}, {24'b0, m_a});
    step();
  endtask

  task automatic jtag_a(input logic [7:0] a, input bit rd, input bit go);
    jdo = 38'($urandom);
    jdo[33:26] = a;
    jdo[34] = rd;
    jdo[35] = go;
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    m_a = a;
    if (go) begin m_go = 1'b1; m_rdy = 1'b0; m_err = 1'b0; end
    chk("jtag_a_addr", {24'b0, dut.mon_a_q}, {24'b0, m_a});
    if (rd) jtag_read_tail("jtag_a_rd");
    else repeat (3) step();
  endtask

  task automatic jtag_noa();
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    m_a = m_a + 8'd1;
    jtag_read_tail("jtag_noa");
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = 38'($urandom);
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
    step();
    m_mem[m_a] = d;
    m_d = d;
    m_a = m_a + 8'd1;
    chk("jtag_b_mondreg", MonDReg, m_d);
    chk("jtag_b_addr", {24'b0, dut.mon_a_q}, {24'b0, m_a});
    repeat (2) step();
  endtask

  task automatic cpu_xfer(input bit wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    rd = 'x;
    avs_address = a; avs_write = wr; avs_read = !wr;
    avs_writedata = d; avs_byteenable = be;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin rd = avs_readdata; done = 1'b1; end
      step();
      if (done) break;
      waits++;
    end
    avs_write = 1'b0; avs_read = 1'b0;
    chk("cpu_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic cpu_ram_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd;
    int w;
    cpu_xfer(1'b1, {1'b0, a}, d, be, rd, w);
    for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic cpu_ram_read_chk(input logic [7:0] a);
    logic [31:0] rd;
    int w;
    cpu_xfer(1'b0, {1'b0, a}, 32'h0, 4'hF, rd, w);
    chk("cpu_rd_data", rd, m_mem[a]);
    chk("cpu_rd_waits", w, 32'd1);
  endtask

  task automatic ctl_write(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd;
    int w;
    cpu_xfer(1'b1, 9'h100, d, be, rd, w);
    chk("ctl_wr_waits", w, 32'd0);
    if (be[0]) begin
      if (d[0]) m_rdy = 1'b1;
      if (d[1]) m_err = 1'b1;
      if (d[2]) m_go = 1'b0;
    end
  endtask

  task automatic ctl_read_chk();
    logic [31:0] rd;
    int w;
    cpu_xfer(1'b0, 9'h100, 32'h0, 4'hF, rd, w);
    chk("ctl_rd_data", rd, {29'b0, m_go, m_err, m_rdy});
    chk("ctl_rd_waits", w, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d;
    logic [7:0]  a;
    int          w;
    bit          done;

    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    m_a = 0; m_d = 0; m_go = 0; m_err = 0; m_rdy = 0;
    repeat (3) step();

    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_wait", {31'b0, avs_waitrequest}, 32'd1);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk_ctl("rst");

    // Release with a CPU write already pending: first cycle must stall.
    reset_n = 1'b1;
    avs_write = 1'b1; avs_address = 9'h000; avs_writedata = 32'h0; avs_byteenable = 4'hF;
    @(negedge clk);
    chk("post_rst_wait0", {31'b0, avs_waitrequest}, 32'd1);
    step();
    @(negedge clk);
    chk("post_rst_wait1", {31'b0, avs_waitrequest}, 32'd0);
    step();
    avs_write = 1'b0;

    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 32'h0;
      cpu_ram_write(8'(i), 32'h0, 4'hF);
    end

    // JTAG write then read back.
    jtag_a(8'h10, 1'b0, 1'b0);
    jtag_b(32'hDEADBEEF);
    jtag_a(8'h10, 1'b1, 1'b0);
    chk("jtag_rw_val", MonDReg, 32'hDEADBEEF);

    // Address wrap on auto-increment.
    cpu_ram_write(8'h00, 32'hA5A55A5A, 4'hF);
    jtag_a(8'hFF, 1'b0, 1'b0);
    jtag_noa();
    chk("wrap_val", MonDReg, 32'hA5A55A5A);

    // CPU byte-lane write.
    cpu_ram_write(8'h05, 32'h11223344, 4'b0101);
    cpu_ram_read_chk(8'h05);
    chk("byte_wr_val", m_mem[5], 32'h00220044);

    // Arbitration: JTAG write and CPU read in the same cycle.
    d = $urandom;
    a = m_a;
    jdo = 38'($urandom);
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    avs_read = 1'b1; avs_address = {1'b0, a};
    done = 1'b0; w = 0; rd = 'x;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin rd = avs_readdata; done = 1'b1; end
      step();
      take_action_ocimem_b = 1'b0;
      if (done) break;
      w++;
    end
    avs_read = 1'b0;
    m_mem[a] = d; m_d = d; m_a = m_a + 8'd1;
    chk("arb_done", {31'b0, done}, 32'd1);
    chk("arb_data", rd, d);
    chk("arb_waits", w, 32'd3);
    chk("arb_mondreg", MonDReg, d);

    // Control handshake.
    jtag_a(8'($urandom), 1'b0, 1'b1);
    chk_ctl("go_pulse");
    ctl_write(32'h1, 4'h1);
    chk_ctl("ctl_rdy");
    ctl_read_chk();
    ctl_write(32'h4, 4'h0);
    ctl_read_chk();
    ctl_write(32'h6, 4'h1);
    chk_ctl("ctl_err");
    ctl_read_chk();
    jtag_a(8'($urandom), 1'b0, 1'b1);
    ctl_read_chk();

    // Randomized mix of JTAG and CPU traffic.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: cpu_ram_write(8'($urandom), $urandom, 4'($urandom));
        1: cpu_ram_read_chk(8'($urandom));
        2: begin jtag_a(8'($urandom), 1'b0, 1'b0); jtag_b($urandom); end
        3: jtag_a(8'($urandom), 1'b1, 1'b0);
        default: jtag_noa();
      endcase
    end
    chk_ctl("rand_end");

    // Asynchronous reset while in JRD_CAP.
    jtag_b(32'hCAFEF00D);
    jdo = 38'($urandom);
    jdo[33:26] = 8'h20;
    jdo[34] = 1'b1;
    jdo[35] = 1'b0;
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    step();
    chk("pre_rst_state", 32'(dut.state_q), 32'(ST_JRD_CAP));
    reset_n = 1'b0;
    #1;
    chk("arst_mondreg", MonDReg, 32'h0);
    chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("arst_wait", {31'b0, avs_waitrequest}, 32'd1);
    m_go = 0; m_err = 0; m_rdy = 0;
    chk_ctl("arst");
    step();
    reset_n = 1'b1;
    repeat (4) step();
    chk("arst_after_mondreg", MonDReg, 32'h0);
    chk("arst_after_addr", {24'b0, dut.mon_a_q}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
